// File: rtl/riscv_encoder.sv
// RV32I instruction encoder: packs a field set into a 32-bit word and queues it
// with an error sideband in an output FIFO. Define RISCV_ENCODER_CHECK_EN to flag op/imm misuse.
module riscv_encoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  format_i,
  input  logic [6:0]  op_i,
  input  logic [2:0]  funct_3_i,
  input  logic [6:0]  funct_7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_o,
  output logic        err_o,
  output logic [15:0] enc_count_o,
  output logic [15:0] err_count_o
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [WORD_W-1:0] enc_word_c;
  logic              enc_err_c;
  logic              chk_err_c;
  logic [WORD_W:0]   entry_d;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  enc_count_q, enc_count_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [WORD_W:0]   mem_q [FIFO_DEPTH];

  logic              full_c;
  logic              empty_c;
  logic              push_c;
  logic              pop_c;
  logic [WORD_W:0]   head_c;

  // Field packing per RV32I format; reserved formats give a zero word flagged as error.
  always_comb begin
    enc_word_c = '0;
    enc_err_c  = 1'b0;
    case (format_i)
      FMT_R: enc_word_c = {funct_7_i, rs2_i, rs1_i, funct_3_i, rd_i, op_i};
      FMT_I: enc_word_c = {imm_i[11:0], rs1_i, funct_3_i, rd_i, op_i};
      FMT_S: enc_word_c = {imm_i[11:5], rs2_i, rs1_i, funct_3_i, imm_i[4:0], op_i};
      FMT_B: enc_word_c = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct_3_i,
                           imm_i[4:1], imm_i[11], op_i};
      FMT_U: enc_word_c = {imm_i[31:12], rd_i, op_i};
      FMT_J: enc_word_c = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
      default: enc_err_c = 1'b1;
    endcase
  end

`ifdef RISCV_ENCODER_CHECK_EN
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic op_bad_c;
  logic imm_bad_c;

  // Opcode must belong to the selected format and imm must fit the encodable range.
  always_comb begin
    op_bad_c  = 1'b0;
    imm_bad_c = 1'b0;
    case (format_i)
      FMT_R: op_bad_c = (op_i != OP_OP);
      FMT_I: begin
        op_bad_c  = !((op_i == OP_IMM) || (op_i == OP_LOAD) || (op_i == OP_JALR));
        imm_bad_c = (imm_i[31:11] != {21{imm_i[11]}});
      end
      FMT_S: begin
        op_bad_c  = (op_i != OP_STORE);
        imm_bad_c = (imm_i[31:11] != {21{imm_i[11]}});
      end
      FMT_B: begin
        op_bad_c  = (op_i != OP_BRANCH);
        imm_bad_c = (imm_i[31:12] != {20{imm_i[12]}}) || imm_i[0];
      end
      FMT_U: begin
        op_bad_c  = !((op_i == OP_LUI) || (op_i == OP_AUIPC));
        imm_bad_c = (imm_i[11:0] != 12'h000);
      end
      FMT_J: begin
        op_bad_c  = (op_i != OP_JAL);
        imm_bad_c = (imm_i[31:20] != {12{imm_i[20]}}) || imm_i[0];
      end
      default: begin
        op_bad_c  = 1'b0;
        imm_bad_c = 1'b0;
      end
    endcase
  end

  assign chk_err_c = op_bad_c | imm_bad_c;
`else
  assign chk_err_c = 1'b0;
`endif

  assign entry_d = {enc_err_c | chk_err_c, enc_word_c};

  assign full_c     = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty_c    = (level_q == '0);
  assign in_ready_o = rst_ni && !full_c && !flush_i;
  assign push_c     = in_valid_i && in_ready_o;
  assign pop_c      = !empty_c && out_ready_i && !flush_i;

  // Pointer, level and counter update; flush empties the queue but leaves counters alone.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
    if (push_c) begin
      enc_count_d = enc_count_q + CNT_W'(1);
      if (entry_d[WORD_W] && (err_count_q != '1)) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  // Storage needs no reset: reads are masked by the level.
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= entry_d;
    end
  end

  assign head_c      = mem_q[rd_ptr_q];
  assign out_valid_o = !empty_c;
  assign instr_o     = empty_c ? '0 : head_c[WORD_W-1:0];
  assign err_o       = !empty_c && head_c[WORD_W];
  assign enc_count_o = enc_count_q;
  assign err_count_o = err_count_q;

endmodule

// File: tb/tb_riscv_encoder.sv
// Self-checking bench for riscv_encoder: vector table through a scoreboard plus
// hand-written full/flush/reset sequences. Honors RISCV_ENCODER_CHECK_EN.
`timescale 1ns/1ps
module tb_riscv_encoder;

  localparam int unsigned DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  format_i;
  logic [6:0]  op_i;
  logic [2:0]  funct_3_i;
  logic [6:0]  funct_7_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [31:0] imm_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] instr_o;
  logic        err_o;
  logic [15:0] enc_count_o;
  logic [15:0] err_count_o;

  riscv_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .format_i(format_i), .op_i(op_i), .funct_3_i(funct_3_i), .funct_7_i(funct_7_i),
    .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .instr_o(instr_o),
    .err_o(err_o), .enc_count_o(enc_count_o), .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err_base;
    logic        err_chk;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  vec_t vecs[16];
  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   exp_enc = 0;
  int   exp_err = 0;
  int   n_chk_err;
  bit   mon_en = 1'b0;
  bit   ok;

  function automatic logic vec_err(input vec_t v);
`ifdef RISCV_ENCODER_CHECK_EN
    return v.err_chk;
`else
    return v.err_base;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic set_fields(input vec_t v);
    format_i  = v.fmt;
    op_i      = v.op;
    funct_3_i = v.f3;
    funct_7_i = v.f7;
    rd_i      = v.rd;
    rs1_i     = v.rs1;
    rs2_i     = v.rs2;
    imm_i     = v.imm;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input vec_t v, input bit rand_bp, output bit accepted);
    int c;
    c = 0;
    accepted = 1'b0;
    set_fields(v);
    in_valid_i = 1'b1;
    while (!accepted && c < 200) begin
      if (rand_bp) out_ready_i = 1'($urandom_range(0, 1));
      #1;
      if (in_ready_o) begin
        accepted = 1'b1;
        sb_q.push_back('{instr: v.instr, err: vec_err(v)});
        exp_enc++;
        if (vec_err(v) && exp_err != 16'hFFFF) exp_err++;
      end
      @(negedge clk_i);
      c++;
    end
    in_valid_i = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready_o stayed %b, expected 1", in_ready_o);
    end
  endtask

  task automatic wait_empty(input string name);
    int c;
    bit done;
    c = 0;
    done = 1'b0;
    while (!done && c < 200) begin
      #1;
      done = (sb_q.size() == 0) && !out_valid_o;
      @(negedge clk_i);
      c++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d words pending, expected 0", name, sb_q.size());
    end
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    sb_q.delete();
    exp_enc = 0;
    exp_err = 0;
    rst_ni  = 1'b1;
    @(negedge clk_i);
  endtask

  // Pops and compares the head whenever the DUT will pop it on the next rising edge.
  always @(negedge clk_i) begin
    #1;
    if (rst_ni && mon_en) begin
      if (out_valid_o) begin
        if (out_ready_i && !flush_i) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected: got word %h, expected none", instr_o);
          end else begin
            mon_e = sb_q.pop_front();
            chk("mon_instr", instr_o, mon_e.instr);
            chk("mon_err", 32'(err_o), 32'(mon_e.err));
          end
        end
      end else begin
        chk("idle_instr", instr_o, 32'h0);
        chk("idle_err", 32'(err_o), 32'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            fmt   op      f3    f7      rd     rs1    rs2    imm            instr          eb    ec
    vecs[0]  = '{3'd0, 7'h33, 3'd0, 7'h20, 5'd3,  5'd1,  5'd2,  32'h00000000, 32'h402081B3, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0,  32'hFFFFFFFF, 32'hFFF00093, 1'b0, 1'b0};
    vecs[2]  = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000800, 32'h0010006F, 1'b0, 1'b0};
    vecs[3]  = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0,  5'd1,  5'd2,  32'h00000008, 32'h00208463, 1'b0, 1'b0};
    vecs[4]  = '{3'd2, 7'h23, 3'd2, 7'h00, 5'd0,  5'd2,  5'd5,  32'h0000000C, 32'h00512623, 1'b0, 1'b0};
    vecs[5]  = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd10, 5'd0,  5'd0,  32'h12345000, 32'h12345537, 1'b0, 1'b0};
    vecs[6]  = '{3'd1, 7'h33, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 32'h00000033, 1'b0, 1'b1};
    vecs[7]  = '{3'd7, 7'h33, 3'd1, 7'h20, 5'd5,  5'd1,  5'd2,  32'h0000007B, 32'h00000000, 1'b1, 1'b1};
    vecs[8]  = '{3'd6, 7'h13, 3'd0, 7'h00, 5'd1,  5'd1,  5'd1,  32'h00000004, 32'h00000000, 1'b1, 1'b1};
    vecs[9]  = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd2,  5'd3,  5'd0,  32'h00000800, 32'h80018113, 1'b0, 1'b1};
    vecs[10] = '{3'd3, 7'h63, 3'd1, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000005, 32'h00001263, 1'b0, 1'b1};
    vecs[11] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0,  32'hFFFFFFFC, 32'hFFDFF0EF, 1'b0, 1'b0};
    vecs[12] = '{3'd4, 7'h17, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00001001, 32'h00001017, 1'b0, 1'b1};
    vecs[13] = '{3'd0, 7'h13, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 32'h00000013, 1'b0, 1'b1};
    vecs[14] = '{3'd3, 7'h63, 3'd1, 7'h00, 5'd0,  5'd1,  5'd2,  32'hFFFFFFF8, 32'hFE209CE3, 1'b0, 1'b0};
    vecs[15] = '{3'd1, 7'h03, 3'd2, 7'h00, 5'd4,  5'd5,  5'd0,  32'hFFFFF800, 32'h8002A203, 1'b0, 1'b0};

    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    set_fields(vecs[0]);
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_in_ready", 32'(in_ready_o), 32'h0);
    chk("rst_out_valid", 32'(out_valid_o), 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_enc_count", 32'(enc_count_o), 32'h0);
    chk("rst_err_count", 32'(err_count_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    @(negedge clk_i);
    #1;
    chk("ready_after_reset", 32'(in_ready_o), 32'h1);
    @(negedge clk_i);

    // Latency: nothing visible before the accepting edge, word visible right after it.
    set_fields(vecs[0]);
    in_valid_i = 1'b1;
    #1;
    chk("pre_accept_valid", 32'(out_valid_o), 32'h0);
    chk("pre_accept_ready", 32'(in_ready_o), 32'h1);
    sb_q.push_back('{instr: vecs[0].instr, err: vec_err(vecs[0])});
    exp_enc++;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    chk("lat_valid", 32'(out_valid_o), 32'h1);
    chk("lat_instr", instr_o, 32'h402081B3);
    chk("lat_err", 32'(err_o), 32'h0);
    @(negedge clk_i);
    wait_empty("latency_drain");

    // Table pass without backpressure, then with random backpressure.
    n_chk_err = 0;
    for (int i = 0; i < 16; i++) begin
      send(vecs[i], 1'b0, ok);
      if (vec_err(vecs[i])) n_chk_err++;
    end
    wait_empty("table_drain");
    chk("table_enc_count", 32'(enc_count_o), 32'(exp_enc));
    chk("table_err_count", 32'(err_count_o), 32'(n_chk_err));
    for (int i = 0; i < 16; i++) send(vecs[i], 1'b1, ok);
    out_ready_i = 1'b1;
    wait_empty("bp_drain");
    chk("bp_enc_count", 32'(enc_count_o), 32'(exp_enc));
    chk("bp_err_count", 32'(err_count_o), 32'(2 * n_chk_err));

    // Fill to capacity with the consumer stalled; fifth word waits until a slot frees.
    do_reset();
    out_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) send(vecs[i], 1'b0, ok);
    #1;
    chk("full_ready", 32'(in_ready_o), 32'h0);
    chk("full_valid", 32'(out_valid_o), 32'h1);
    chk("full_enc_count", 32'(enc_count_o), 32'h4);
    @(negedge clk_i);
    set_fields(vecs[5]);
    in_valid_i = 1'b1;
    @(negedge clk_i);
    #1;
    chk("full_hold_ready", 32'(in_ready_o), 32'h0);
    chk("full_hold_enc", 32'(enc_count_o), 32'h4);
    @(negedge clk_i);
    out_ready_i = 1'b1;
    send(vecs[5], 1'b0, ok);
    wait_empty("full_drain");
    chk("full_final_enc", 32'(enc_count_o), 32'h5);

    // Flush with three words buffered and a push attempted on the same edge.
    out_ready_i = 1'b0;
    for (int i = 9; i <= 11; i++) send(vecs[i], 1'b0, ok);
    flush_i = 1'b1;
    set_fields(vecs[6]);
    in_valid_i = 1'b1;
    #1;
    chk("flush_ready", 32'(in_ready_o), 32'h0);
    @(negedge clk_i);
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    sb_q.delete();
    #1;
    chk("flush_valid", 32'(out_valid_o), 32'h0);
    chk("flush_instr", instr_o, 32'h0);
    chk("flush_enc_count", 32'(enc_count_o), 32'(exp_enc));
    @(negedge clk_i);
    out_ready_i = 1'b1;
    send(vecs[14], 1'b0, ok);
    wait_empty("post_flush_drain");

    // Reset while draining discards everything and clears counters.
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(vecs[i], 1'b0, ok);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid_o), 32'h0);
    chk("midrst_instr", instr_o, 32'h0);
    chk("midrst_err", 32'(err_o), 32'h0);
    chk("midrst_ready", 32'(in_ready_o), 32'h0);
    chk("midrst_enc", 32'(enc_count_o), 32'h0);
    sb_q.delete();
    exp_enc = 0;
    exp_err = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Checker-dependent error flagging from fresh counters.
    send(vecs[6], 1'b0, ok);
    wait_empty("chk_fmt_drain");
`ifdef RISCV_ENCODER_CHECK_EN
    chk("opmismatch_err_count", 32'(err_count_o), 32'h1);
`else
    chk("opmismatch_err_count", 32'(err_count_o), 32'h0);
`endif
    send(vecs[7], 1'b0, ok);
    wait_empty("fmt7_drain");
`ifdef RISCV_ENCODER_CHECK_EN
    chk("fmt7_err_count", 32'(err_count_o), 32'h2);
`else
    chk("fmt7_err_count", 32'(err_count_o), 32'h1);
`endif
    chk("final_enc_count", 32'(enc_count_o), 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
